// File: rtl/sent_rx.sv
// Single-channel SENT frame decoder: measures falling-edge periods in ticks, recovers nibbles and checks the CRC.
// Optional build macro SENT_RX_GLITCH_FILTER_EN adds a 3-sample majority filter after the input synchronizer.
module sent_rx #(
   parameter int CHANNEL_INDEX = 0,
   parameter int CLK_FREQ      = 100000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sent_config_vld,
   input  logic [7:0]  sent_config_channel,
   input  logic [7:0]  sent_ctick_len,
   input  logic        sent_crc_mode,
   input  logic        sent_in,
   output logic        rx_frame_vld,
   output logic [31:0] rx_frame_data,
   output logic        rx_crc_err,
   output logic        rx_sync_err,
   output logic        rx_busy
);

   localparam int          CLK_MHZ      = CLK_FREQ / 1000000;
   localparam logic [16:0] TICK_CLK_RST = 17'(3 * CLK_MHZ);

   typedef enum logic [3:0] {
      ST_SYNC, ST_MEAS_CAL, ST_STATUS, ST_D0, ST_D1, ST_D2,
      ST_D3, ST_D4, ST_D5, ST_CRC, ST_END
   } state_t;

   function automatic logic [3:0] crc_table(input logic [3:0] idx);
      case (idx)
         4'h0: return 4'd0;   4'h1: return 4'd13;  4'h2: return 4'd7;   4'h3: return 4'd10;
         4'h4: return 4'd14;  4'h5: return 4'd3;   4'h6: return 4'd9;   4'h7: return 4'd4;
         4'h8: return 4'd1;   4'h9: return 4'd12;  4'ha: return 4'd6;   4'hb: return 4'd11;
         4'hc: return 4'd15;  4'hd: return 4'd2;   4'he: return 4'd8;   4'hf: return 4'd5;
         default: return 4'd0;
      endcase
   endfunction

   // Line synchronizer; flops reset high so the idle line does not look like an edge.
   logic sync1_reg, sync2_reg, line_prev_reg, line_cur, fe;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= sent_in;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef SENT_RX_GLITCH_FILTER_EN
   logic [1:0] hist_reg;
   logic       filt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_reg <= 2'b11;
         filt_reg <= 1'b1;
      end else begin
         hist_reg <= {hist_reg[0], sync2_reg};
         filt_reg <= (sync2_reg & hist_reg[0]) | (sync2_reg & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
      end
   end

   assign line_cur = filt_reg;
`else
   assign line_cur = sync2_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) line_prev_reg <= 1'b1;
      else     line_prev_reg <= line_cur;
   end

   assign fe = line_prev_reg & ~line_cur;

   // Latched configuration is only copied into the active set on a falling edge.
   logic [7:0]  ctick_len_reg;
   logic        crc_mode_reg, crc_mode_act_reg;
   logic [16:0] tick_clk_reg, presc_reg;
   logic [9:0]  tick_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctick_len_reg    <= 8'd3;
         crc_mode_reg     <= 1'b1;
         crc_mode_act_reg <= 1'b1;
         tick_clk_reg     <= TICK_CLK_RST;
      end else begin
         if (sent_config_vld && sent_config_channel == 8'(CHANNEL_INDEX)) begin
            ctick_len_reg <= sent_ctick_len;
            crc_mode_reg  <= sent_crc_mode;
         end
         if (fe) begin
            tick_clk_reg     <= 17'(32'(ctick_len_reg) * CLK_MHZ);
            crc_mode_act_reg <= crc_mode_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || fe) begin
         presc_reg    <= '0;
         tick_cnt_reg <= '0;
      end else if (presc_reg == tick_clk_reg - 17'd1) begin
         presc_reg <= '0;
         if (tick_cnt_reg != 10'd1023) tick_cnt_reg <= tick_cnt_reg + 10'd1;
      end else begin
         presc_reg <= presc_reg + 17'd1;
      end
   end

   logic [10:0] ticks;
   logic [3:0]  nib;
   logic        is_cal, is_nib, is_pause, timeout;

   assign ticks    = {1'b0, tick_cnt_reg} + 11'(presc_reg >= (tick_clk_reg >> 1));
   assign nib      = ticks[3:0] + 4'd4;
   assign is_cal   = (ticks >= 11'd55) && (ticks <= 11'd57);
   assign is_nib   = (ticks >= 11'd12) && (ticks <= 11'd27);
   assign is_pause = (ticks >= 11'd12) && (ticks <= 11'd768);

   state_t state_reg, state_next;

   assign timeout = !fe && (tick_cnt_reg == 10'd1023) && (state_reg != ST_SYNC);

   always_ff @(posedge clk) begin
      if (rst) state_reg <= ST_SYNC;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (fe) begin
         case (state_reg)
            ST_SYNC:     state_next = ST_MEAS_CAL;
            ST_MEAS_CAL: state_next = is_cal ? ST_STATUS : ST_MEAS_CAL;
            ST_STATUS:   state_next = is_nib ? ST_D0  : ST_MEAS_CAL;
            ST_D0:       state_next = is_nib ? ST_D1  : ST_MEAS_CAL;
            ST_D1:       state_next = is_nib ? ST_D2  : ST_MEAS_CAL;
            ST_D2:       state_next = is_nib ? ST_D3  : ST_MEAS_CAL;
            ST_D3:       state_next = is_nib ? ST_D4  : ST_MEAS_CAL;
            ST_D4:       state_next = is_nib ? ST_D5  : ST_MEAS_CAL;
            ST_D5:       state_next = is_nib ? ST_CRC : ST_MEAS_CAL;
            ST_CRC:      state_next = is_nib ? ST_END : ST_MEAS_CAL;
            ST_END:      state_next = is_cal ? ST_STATUS : ST_MEAS_CAL;
            default:     state_next = ST_SYNC;
         endcase
      end else if (timeout) begin
         state_next = ST_SYNC;
      end
   end

   logic [27:0] nib_sr_reg, nib_sr_next;
   logic [3:0]  crc_acc_reg, crc_acc_next, crc_rx_reg, crc_rx_next, crc_exp;
   logic [31:0] data_next;
   logic        frame_vld_next, crc_err_next, sync_err_next, busy_next;

   assign crc_exp = crc_mode_act_reg ? crc_table(crc_acc_reg) : crc_acc_reg;

   always_comb begin
      frame_vld_next = 1'b0;
      crc_err_next   = 1'b0;
      sync_err_next  = 1'b0;
      busy_next      = rx_busy;
      nib_sr_next    = nib_sr_reg;
      crc_acc_next   = crc_acc_reg;
      crc_rx_next    = crc_rx_reg;
      data_next      = rx_frame_data;
      if (fe) begin
         if (state_reg == ST_MEAS_CAL) begin
            if (is_cal) begin
               busy_next    = 1'b1;
               crc_acc_next = 4'd5;
            end
         end else if (state_reg inside {ST_STATUS, ST_D0, ST_D1, ST_D2, ST_D3, ST_D4, ST_D5, ST_CRC}) begin
            if (!is_nib) begin
               sync_err_next = 1'b1;
               busy_next     = 1'b0;
            end else if (state_reg == ST_CRC) begin
               crc_rx_next = nib;
            end else begin
               nib_sr_next = {nib_sr_reg[23:0], nib};
               if (state_reg != ST_STATUS) crc_acc_next = crc_table(crc_acc_reg) ^ nib;
            end
         end else if (state_reg == ST_END) begin
            if (!is_pause) begin
               sync_err_next = 1'b1;
               busy_next     = 1'b0;
            end else begin
               if (crc_exp == crc_rx_reg) begin
                  frame_vld_next = 1'b1;
                  data_next      = {nib_sr_reg, crc_rx_reg};
               end else begin
                  crc_err_next = 1'b1;
               end
               // A calibration pulse here starts the next frame immediately.
               busy_next = is_cal;
               if (is_cal) crc_acc_next = 4'd5;
            end
         end
      end else if (timeout) begin
         sync_err_next = (state_reg != ST_MEAS_CAL);
         busy_next     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_frame_vld  <= 1'b0;
         rx_crc_err    <= 1'b0;
         rx_sync_err   <= 1'b0;
         rx_busy       <= 1'b0;
         rx_frame_data <= '0;
         nib_sr_reg    <= '0;
         crc_acc_reg   <= '0;
         crc_rx_reg    <= '0;
      end else begin
         rx_frame_vld  <= frame_vld_next;
         rx_crc_err    <= crc_err_next;
         rx_sync_err   <= sync_err_next;
         rx_busy       <= busy_next;
         rx_frame_data <= data_next;
         nib_sr_reg    <= nib_sr_next;
         crc_acc_reg   <= crc_acc_next;
         crc_rx_reg    <= crc_rx_next;
      end
   end

endmodule

// File: tb/tb_sent_rx.sv
// Directed bench for sent_rx: hand-computed SENT frames driven on the line, pulses counted by a monitor.
module tb_sent_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sent_config_vld = 1'b0;
   logic [7:0]  sent_config_channel = 8'd0;
   logic [7:0]  sent_ctick_len = 8'd3;
   logic        sent_crc_mode = 1'b1;
   logic        sent_in = 1'b1;
   logic        rx_frame_vld, rx_crc_err, rx_sync_err, rx_busy;
   logic [31:0] rx_frame_data;

   int n_checks = 0;
   int n_pass   = 0;
   int n_vld    = 0;
   int n_crc    = 0;
   int n_sync   = 0;
   int tclk     = 12;   // clocks per tick: 3 us at 4 MHz

   sent_rx #(.CHANNEL_INDEX(0), .CLK_FREQ(4000000)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .sent_config_vld     (sent_config_vld),
      .sent_config_channel (sent_config_channel),
      .sent_ctick_len      (sent_ctick_len),
      .sent_crc_mode       (sent_crc_mode),
      .sent_in             (sent_in),
      .rx_frame_vld        (rx_frame_vld),
      .rx_frame_data       (rx_frame_data),
      .rx_crc_err          (rx_crc_err),
      .rx_sync_err         (rx_sync_err),
      .rx_busy             (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_frame_vld) begin
            n_vld++;
            $display("t=%0t rx_frame_vld data=%h", $time, rx_frame_data);
         end
         if (rx_crc_err) begin
            n_crc++;
            $display("t=%0t rx_crc_err", $time);
         end
         if (rx_sync_err) begin
            n_sync++;
            $display("t=%0t rx_sync_err", $time);
         end
         if (rx_frame_vld | rx_crc_err | rx_sync_err)
            chk("exclusive", 32'($onehot({rx_frame_vld, rx_crc_err, rx_sync_err})), 32'd1);
      end
   end

   task automatic pulse(input int t);
      sent_in = 1'b0;
      repeat (4 * tclk) @(negedge clk);
      sent_in = 1'b1;
      repeat ((t - 4) * tclk) @(negedge clk);
   endtask

   task automatic send_body(input logic [3:0] s, input logic [23:0] d, input logic [3:0] c);
      pulse(12 + int'(s));
      for (int i = 5; i >= 0; i--) pulse(12 + int'(d[i*4 +: 4]));
      pulse(12 + int'(c));
   endtask

   task automatic send_frame(input logic [3:0] s, input logic [23:0] d, input logic [3:0] c);
      pulse(56);
      send_body(s, d, c);
   endtask

   task automatic close_edge();
      sent_in = 1'b0;
      repeat (4 * tclk) @(negedge clk);
      sent_in = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic cfg(input logic [7:0] ch, input logic [7:0] len, input logic mode);
      @(negedge clk);
      sent_config_vld     = 1'b1;
      sent_config_channel = ch;
      sent_ctick_len      = len;
      sent_crc_mode       = mode;
      @(negedge clk);
      sent_config_vld     = 1'b0;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_vld", 32'(rx_frame_vld), 32'd0);
      chk("rst_crc_err", 32'(rx_crc_err), 32'd0);
      chk("rst_sync_err", 32'(rx_sync_err), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      chk("rst_data", rx_frame_data, 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Legacy CRC, back-to-back frames, then a 200-tick pause
      cfg(8'd0, 8'd3, 1'b0);
      send_frame(4'h0, 24'h123456, 4'hD);
      chk("legacy_busy_mid", 32'(rx_busy), 32'd1);
      send_frame(4'h5, 24'h654321, 4'h4);
      chk("legacy_vld_a", 32'(n_vld), 32'd1);
      chk("legacy_data_a", rx_frame_data, 32'h0123456D);
      pulse(200);
      close_edge();
      chk("pause_vld_b", 32'(n_vld), 32'd2);
      chk("pause_data_b", rx_frame_data, 32'h56543214);
      chk("pause_busy", 32'(rx_busy), 32'd0);
      chk("pause_no_crc_err", 32'(n_crc), 32'd0);
      chk("pause_no_sync_err", 32'(n_sync), 32'd0);

      // Recommended CRC: good frame then a frame carrying the legacy CRC
      cfg(8'd0, 8'd3, 1'b1);
      send_frame(4'h0, 24'h123456, 4'h2);
      send_frame(4'h0, 24'h123456, 4'hD);
      pulse(200);
      close_edge();
      chk("rec_vld", 32'(n_vld), 32'd3);
      chk("rec_crc_err", 32'(n_crc), 32'd1);
      chk("rec_data_held", rx_frame_data, 32'h01234562);

      // 30-tick data nibble, then a well-formed frame
      pulse(56);
      pulse(12);
      pulse(13);
      pulse(30);
      sent_in = 1'b0;
      repeat (20) @(negedge clk);
      chk("range_sync_err", 32'(n_sync), 32'd1);
      chk("range_busy", 32'(rx_busy), 32'd0);
      repeat (4 * tclk - 20) @(negedge clk);
      sent_in = 1'b1;
      repeat (52 * tclk) @(negedge clk);
      send_body(4'hA, 24'h123456, 4'h2);
      pulse(200);
      close_edge();
      chk("recover_vld", 32'(n_vld), 32'd4);
      chk("recover_data", rx_frame_data, 32'hA1234562);

      // Line stuck low mid-frame
      pulse(56);
      pulse(12);
      sent_in = 1'b0;
      repeat (1030 * tclk) @(negedge clk);
      sent_in = 1'b1;
      repeat (20) @(negedge clk);
      chk("timeout_sync_err", 32'(n_sync), 32'd2);
      chk("timeout_busy", 32'(rx_busy), 32'd0);

      // Non-matching channel write is ignored
      cfg(8'd5, 8'd10, 1'b1);
      send_frame(4'h3, 24'h123456, 4'h2);
      pulse(200);
      close_edge();
      chk("nomatch_vld", 32'(n_vld), 32'd5);
      chk("nomatch_data", rx_frame_data, 32'h31234562);

      // Matching write: 10 us ticks
      cfg(8'd0, 8'd10, 1'b1);
      tclk = 40;
      send_frame(4'h0, 24'h654321, 4'hE);
      pulse(200);
      close_edge();
      chk("tick10_vld", 32'(n_vld), 32'd6);
      chk("tick10_data", rx_frame_data, 32'h0654321E);
      chk("final_sync_err", 32'(n_sync), 32'd2);
      chk("final_crc_err", 32'(n_crc), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
